// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port unified instruction/data RAM between
// the instruction-fetch requester (read-only) and the load/store requester.
//
// Handshake rule (requests and responses alike): a transfer happens on the
// rising clk edge where valid && ready are both high. The source holds its
// payload stable while valid && !ready. Request readies are combinational,
// are raised only in IDLE, and go only to the granted port.
//
// Transaction flow: IDLE -(accept, E0)-> ISSUE -(RAM samples, E1)->
// CAPTURE -(rd registered, E2)-> RESP -(rsp handshake)-> IDLE.
// Ties are broken round-robin; last_grant resets to DATA so fetch wins first.
//
// Optional build macro RAM_ARB_RANGE_CHECK_EN: when defined, an address
// >= MEM_WORDS is still run through the full sequence, but the write is
// suppressed, the response data is 0 and the port's err flag is raised.
// When undefined, no check is made and both err outputs stay 0.
module ram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    // fetch port
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_rsp_valid,
    input  logic              f_rsp_ready,
    output logic [DATA_W-1:0] f_rsp_rdata,
    output logic              f_rsp_err,
    // data port
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_rdata,
    output logic              d_rsp_err,
    // RAM side
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    // status / debug
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;   // 1 = data port was granted last, 0 = fetch
    logic   cur_d;        // port owning the transaction in flight (1 = data)
    logic   cur_we;       // transaction in flight is a store
    logic   oor_q;        // transaction in flight is out of range
    logic   f_err_q;
    logic   d_err_q;
    logic   grant_f;
    logic   grant_d;
    logic   f_oor;
    logic   d_oor;
    logic   rsp_done;

`ifdef RAM_ARB_RANGE_CHECK_EN
    // Out-of-range detection on the incoming request addresses.
    assign f_oor = (f_req_addr >= ADDR_W'(MEM_WORDS));
    assign d_oor = (d_req_addr >= ADDR_W'(MEM_WORDS));
`else
    assign f_oor = 1'b0;
    assign d_oor = 1'b0;
`endif

    // Round-robin grant: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        grant_f     = f_req_valid && (!d_req_valid || last_grant);
        grant_d     = d_req_valid && (!f_req_valid || !last_grant);
        f_req_ready = (state == IDLE) && grant_f;
        d_req_ready = (state == IDLE) && grant_d;
        rsp_done    = cur_d ? d_rsp_ready : f_rsp_ready;
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign f_rsp_err = f_err_q;
    assign d_rsp_err = d_err_q;

    // Transaction sequencer: owns every registered output and the grant history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cur_d       <= 1'b0;
            cur_we      <= 1'b0;
            oor_q       <= 1'b0;
            mem_we      <= 1'b0;
            mem_a       <= '0;
            mem_wd      <= '0;
            f_rsp_valid <= 1'b0;
            f_rsp_rdata <= '0;
            f_err_q     <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rsp_rdata <= '0;
            d_err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_req_ready) begin
                        mem_a      <= f_req_addr;
                        mem_wd     <= '0;
                        mem_we     <= 1'b0;
                        cur_d      <= 1'b0;
                        cur_we     <= 1'b0;
                        oor_q      <= f_oor;
                        last_grant <= 1'b0;
                        state      <= ISSUE;
                    end else if (d_req_ready) begin
                        mem_a      <= d_req_addr;
                        mem_wd     <= d_req_wdata;
                        mem_we     <= d_req_we && !d_oor;
                        cur_d      <= 1'b1;
                        cur_we     <= d_req_we;
                        oor_q      <= d_oor;
                        last_grant <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The RAM samples we/a/wd on this edge; the write pulse ends here.
                    mem_we <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (cur_d) begin
                        d_rsp_valid <= 1'b1;
                        d_rsp_rdata <= (cur_we || oor_q) ? '0 : mem_rd;
                        d_err_q     <= oor_q;
                    end else begin
                        f_rsp_valid <= 1'b1;
                        f_rsp_rdata <= oor_q ? '0 : mem_rd;
                        f_err_q     <= oor_q;
                    end
                    state <= RESP;
                end
                RESP: begin
                    // rdata is left as-is after the handshake; only valid/err drop.
                    if (rsp_done) begin
                        f_rsp_valid <= 1'b0;
                        f_err_q     <= 1'b0;
                        d_rsp_valid <= 1'b0;
                        d_err_q     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural RAM,
// per-port expected-response queues and a grant-order queue checked by
// monitors that run independently of the stimulus.
module tb_ram_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 128;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              f_req_valid = 1'b0;
    logic              f_req_ready;
    logic [ADDR_W-1:0] f_req_addr = '0;
    logic              f_rsp_valid;
    logic              f_rsp_ready = 1'b1;
    logic [DATA_W-1:0] f_rsp_rdata;
    logic              f_rsp_err;
    logic              d_req_valid = 1'b0;
    logic              d_req_ready;
    logic              d_req_we = 1'b0;
    logic [ADDR_W-1:0] d_req_addr = '0;
    logic [DATA_W-1:0] d_req_wdata = '0;
    logic              d_rsp_valid;
    logic              d_rsp_ready = 1'b1;
    logic [DATA_W-1:0] d_rsp_rdata;
    logic              d_rsp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic              busy;
    logic [1:0]        dbg_state;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_rdata(f_rsp_rdata),
        .f_rsp_err(f_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
        .d_rsp_err(d_rsp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy), .dbg_state(dbg_state)
    );

    // behavioural single-port RAM with registered read; preload while 'preload' is high
    logic              preload = 1'b1;
    logic [DATA_W-1:0] ram [0:255];
    always @(posedge clk) begin
        if (preload) ram[0] <= 32'h0050_0113;
        else if (mem_we) ram[mem_a[7:0]] <= mem_wd;
        mem_rd <= ram[mem_a[7:0]];
    end

    // scoreboard state
    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    logic [DATA_W:0] f_exp_q[$];   // {err, rdata}
    logic [DATA_W:0] d_exp_q[$];
    logic [0:0]      grant_exp_q[$]; // 0 = fetch, 1 = data

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // monitor: responses, grants, write pulses, response exclusivity
    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (f_rsp_valid || d_rsp_valid) chk("rsp_excl", {63'd0, f_rsp_valid && d_rsp_valid}, 64'd0);
        if (f_rsp_valid && f_rsp_ready) begin
            if (f_exp_q.size() == 0) chk("f_rsp_unexpected", 64'd1, 64'd0);
            else chk("f_rsp", {31'd0, f_rsp_err, f_rsp_rdata}, {31'd0, f_exp_q.pop_front()});
        end
        if (d_rsp_valid && d_rsp_ready) begin
            if (d_exp_q.size() == 0) chk("d_rsp_unexpected", 64'd1, 64'd0);
            else chk("d_rsp", {31'd0, d_rsp_err, d_rsp_rdata}, {31'd0, d_exp_q.pop_front()});
        end
        if (f_req_valid && f_req_ready) begin
            if (grant_exp_q.size() == 0) chk("grant_unexpected_f", 64'd1, 64'd0);
            else chk("grant_order_f", 64'd0, {63'd0, grant_exp_q.pop_front()});
        end
        if (d_req_valid && d_req_ready) begin
            if (grant_exp_q.size() == 0) chk("grant_unexpected_d", 64'd1, 64'd0);
            else chk("grant_order_d", 64'd1, {63'd0, grant_exp_q.pop_front()});
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({tag, "_mem_a"}, {32'd0, mem_a}, 64'd0);
        chk({tag, "_mem_wd"}, {32'd0, mem_wd}, 64'd0);
        chk({tag, "_f_rsp_valid"}, {63'd0, f_rsp_valid}, 64'd0);
        chk({tag, "_d_rsp_valid"}, {63'd0, d_rsp_valid}, 64'd0);
        chk({tag, "_f_rsp_rdata"}, {32'd0, f_rsp_rdata}, 64'd0);
        chk({tag, "_d_rsp_rdata"}, {32'd0, d_rsp_rdata}, 64'd0);
        chk({tag, "_errs"}, {62'd0, f_rsp_err, d_rsp_err}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    // driver: raise the requested ports and hold each until it is accepted
    task automatic issue(input logic f_en, input logic [ADDR_W-1:0] fa,
                         input logic d_en, input logic dwe,
                         input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd);
        logic f_done, d_done, f_acc, d_acc;
        int cyc;
        f_req_valid = f_en; f_req_addr = fa;
        d_req_valid = d_en; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd;
        f_done = !f_en; d_done = !d_en; cyc = 0;
        while (!(f_done && d_done) && cyc < 60) begin
            @(negedge clk);
            f_acc = f_req_valid && f_req_ready;
            d_acc = d_req_valid && d_req_ready;
            @(posedge clk); #1;
            if (f_acc) begin
                f_req_valid = 1'b0; f_done = 1'b1;
                chk("f_mem_a", {32'd0, mem_a}, {32'd0, fa});
                chk("f_mem_we", {63'd0, mem_we}, 64'd0);
            end
            if (d_acc) begin
                d_req_valid = 1'b0; d_done = 1'b1;
                chk("d_mem_a", {32'd0, mem_a}, {32'd0, da});
            end
            cyc++;
        end
        if (!(f_done && d_done)) begin
            chk("issue_timeout", 64'd1, 64'd0);
            f_req_valid = 1'b0; d_req_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int cyc;
        // power-on reset with RAM preload
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("por");
        preload = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // fetch only
        grant_exp_q.push_back(1'b0); f_exp_q.push_back({1'b0, 32'h0050_0113});
        issue(1, 32'h00, 0, 0, 0, 0);
        // store then load
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'h0});
        issue(0, 0, 1, 1, 32'h3C, 32'hA5A5_0001);
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'hA5A5_0001});
        issue(0, 0, 1, 0, 32'h3C, 0);

        // contention from reset: F, D, F, D
        repeat (8) @(posedge clk);
        #1;
        do_reset();
        grant_exp_q.push_back(1'b0); f_exp_q.push_back({1'b0, 32'h0050_0113});
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'h0});
        issue(1, 32'h00, 1, 1, 32'h20, 32'h0000_BEEF);
        grant_exp_q.push_back(1'b0); f_exp_q.push_back({1'b0, 32'h0000_BEEF});
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'hA5A5_0001});
        issue(1, 32'h20, 1, 0, 32'h3C, 0);
        // after a lone fetch the next tie goes to data
        grant_exp_q.push_back(1'b0); f_exp_q.push_back({1'b0, 32'hA5A5_0001});
        issue(1, 32'h3C, 0, 0, 0, 0);
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'h0000_BEEF});
        grant_exp_q.push_back(1'b0); f_exp_q.push_back({1'b0, 32'h0050_0113});
        issue(1, 32'h00, 1, 0, 32'h20, 0);

        // backpressure: fetch wins (last grant was data), held 5 cycles
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'h0});
        issue(0, 0, 1, 1, 32'h24, 32'h1234_5678);
        f_rsp_ready = 1'b0;
        grant_exp_q.push_back(1'b0); f_exp_q.push_back({1'b0, 32'h1234_5678});
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'h0050_0113});
        fork
            issue(1, 32'h24, 1, 0, 32'h00, 0);
            begin
                cyc = 0;
                while (!f_rsp_valid && cyc < 30) begin @(negedge clk); cyc++; end
                chk("bp_rsp_seen", {63'd0, f_rsp_valid}, 64'd1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_valid_hold", {63'd0, f_rsp_valid}, 64'd1);
                    chk("bp_rdata_hold", {32'd0, f_rsp_rdata}, {32'd0, 32'h1234_5678});
                    chk("bp_d_ready_low", {63'd0, d_req_ready}, 64'd0);
                end
                @(posedge clk); #1;
                f_rsp_ready = 1'b1;
            end
        join

        // reset while a store sits in CAPTURE
        @(posedge clk); #1;
        grant_exp_q.push_back(1'b1);
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h28; d_req_wdata = 32'hDEAD_BEEF;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!d_req_ready && cyc < 30);
        chk("midop_accept", {63'd0, d_req_ready}, 64'd1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        @(posedge clk); #1;
        do_reset();
        repeat (5) @(negedge clk);
        chk("midop_no_rsp", {62'd0, f_rsp_valid, d_rsp_valid}, 64'd0);
        @(posedge clk); #1;
        grant_exp_q.push_back(1'b0); f_exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        issue(1, 32'h28, 0, 0, 0, 0);

        // out-of-range address (200)
`ifdef RAM_ARB_RANGE_CHECK_EN
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b1, 32'h0});
        issue(0, 0, 1, 1, 32'd200, 32'hCAFE_F00D);
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b1, 32'h0});
        issue(0, 0, 1, 0, 32'd200, 0);
`else
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'h0});
        issue(0, 0, 1, 1, 32'd200, 32'hCAFE_F00D);
        grant_exp_q.push_back(1'b1); d_exp_q.push_back({1'b0, 32'hCAFE_F00D});
        issue(0, 0, 1, 0, 32'd200, 0);
`endif

        // drain and final report
        cyc = 0;
        while ((f_exp_q.size() != 0 || d_exp_q.size() != 0) && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        repeat (2) @(negedge clk);
        chk("drain_f", {32'd0, f_exp_q.size()}, 64'd0);
        chk("drain_d", {32'd0, d_exp_q.size()}, 64'd0);
        chk("drain_grant", {32'd0, grant_exp_q.size()}, 64'd0);
`ifdef RAM_ARB_RANGE_CHECK_EN
        chk("we_pulses", {32'd0, we_cnt}, 64'd4);
`else
        chk("we_pulses", {32'd0, we_cnt}, 64'd5);
`endif
        chk("end_idle", {63'd0, busy}, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port unified instruction/data RAM of the multi-cycle RISC-V core between two requesters: the instruction-fetch port (read-only) and the data load/store port (read/write).
- Sits between the core's fetch/LSU logic and the RAM; drives the RAM's `we`, `a` and `wd` inputs and captures its registered `rd`.
- Requests and responses use valid/ready handshakes; contention is resolved round-robin.

Parameters:
- ADDR_W, 32, address width of requests and of mem_a
- DATA_W, 32, data width
- MEM_WORDS, 128, number of RAM entries; upper bound for the range check

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  ADDR_W  fetch address
- f_rsp_valid  out  1  fetch response valid
- f_rsp_ready  in  1  fetch response consumed
- f_rsp_rdata  out  DATA_W  fetched word
- f_rsp_err  out  1  fetch out-of-range (feature)
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_rsp_valid  out  1  data response valid (load data or store ack)
- d_rsp_ready  in  1  data response consumed
- d_rsp_rdata  out  DATA_W  load data (0 for stores)
- d_rsp_err  out  1  data out-of-range (feature)
- mem_we  out  1  to RAM `we`
- mem_a  out  ADDR_W  to RAM `a`
- mem_wd  out  DATA_W  to RAM `wd`
- mem_rd  in  DATA_W  from RAM `rd`; valid one edge after `a` is sampled
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs are 0: mem_we, mem_a, mem_wd, both rsp_valid, both rdata and both err.
  - last_grant = DATA, so fetch wins the first tie.
  - Reset mid-transaction abandons it silently; no response is issued.
- FSM has four states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - f_req_ready and d_req_ready are combinational and are asserted only in IDLE, only toward the granted port.
  - Only one valid request: grant it.
  - Both valid: grant the port not in last_grant.
  - On acceptance edge E0, register mem_a = addr, mem_wd = wdata (0 for fetch), mem_we = d_req_we (0 for fetch), and the granted port id; last_grant is updated.
- ISSUE:
  - mem_* outputs are stable. The RAM samples at edge E1: write happens at E1, and rd updates at E1.
  - At E1, mem_we is cleared.
- CAPTURE: at edge E2, mem_rd is registered into the granted port's rsp_rdata (0 for stores), that port's rsp_valid is set, and the state goes to RESP.
- RESP:
  - rsp_valid, rdata and err stay held until rsp_ready=1.
  - On that handshake edge, rsp_valid and err clear (rdata keeps its value) and the state goes to IDLE.
  - The earliest new acceptance is on the cycle after the handshake.
- Latency: accept at E0 -> rsp_valid high after E2. Minimum 4 cycles per transaction.
- Responses only ever appear on the port that issued the request; the two rsp_valid outputs are never high together.
- mem_a and mem_wd hold their last value in IDLE. mem_we is high for exactly one cycle per store and never for fetch.
- Requester rules:
  - A requester must hold addr/we/wdata stable while valid && !ready.
  - A request that drops valid before acceptance is not granted.
- Simultaneous arrival of rsp_ready and a new req_valid: the response completes first; the request is accepted in the following IDLE cycle.
- Back-to-back contention alternates F, D, F, D...; neither port waits more than one transaction.
- Addresses are passed through unmodified. Byte addresses index the RAM directly; no alignment check.

Optional Feature:
- Macro: RAM_ARB_RANGE_CHECK_EN.
- Defined:
  - A request with addr >= MEM_WORDS is still accepted and still goes IDLE -> ISSUE -> CAPTURE -> RESP, but mem_we stays 0.
  - The response has rdata = 0 and err = 1.
- Undefined:
  - No check is made; f_rsp_err and d_rsp_err are tied to 0.
  - Out-of-range addresses are presented to the RAM unmodified.

Test Plan:
- Fetch only: f_req addr=0x00 with RAM[0]=0x00500113 -> f_req_ready high 1 cycle; mem_a=0x00 after E0; f_rsp_valid after E2 with rdata 0x00500113; mem_we never high.
- Store then load: d_req we=1 addr=0x3C wdata=0xA5A5_0001 -> mem_we pulses exactly 1 cycle; d_rsp_valid with rdata 0. Then load addr=0x3C -> rdata 0xA5A50001.
- Contention: f_req and d_req valid together from reset, held for 4 transactions -> grant order F, D, F, D; never both rsp_valid.
- Backpressure: hold f_rsp_ready=0 for 5 cycles -> f_rsp_valid/rdata stable; d_req_ready stays 0 until the handshake; then D is granted.
- Reset mid-op: reset_n=0 in CAPTURE of a store -> all outputs 0 immediately, busy=0, no rsp_valid after release; next fetch after release is served normally.
- With RAM_ARB_RANGE_CHECK_EN: d_req we=1 addr=200 -> mem_we stays 0; d_rsp_err=1, rdata=0. Without the macro: mem_we pulses, err=0.
